// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional feature macro: INST_FETCH_ALIGN_CHECK_EN (fetch-address alignment exception).
package inst_fetch_pkg;

    // Reset is asynchronous and active low
    localparam logic        RST_ACTIVE    = 1'b0;

    // Instruction / address widths
    localparam int          INST_W        = 32;
    localparam int          ADDR_W        = 32;
    localparam int          CTRL_W        = 6;

    // Instruction presented when the slot holds nothing
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    // Sequential fetch increment and word-alignment mask
    localparam logic [31:0] PC_STEP       = 32'h0000_0004;
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

    // ctrl_signal bit positions
    localparam int          CTRL_HOLD_PC  = 0;
    localparam int          CTRL_IF_STALL = 1;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,   // free to issue a new request
        ST_WAIT = 2'b01,   // request outstanding, response wanted
        ST_DROP = 2'b10    // request outstanding, response is stale
    } if_state_e;

endpackage

// File: rtl/if_pc_next.sv
// Next program-counter select: flush > branch > sequential +4 > hold.
module if_pc_next
    import inst_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        advance,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        redirect
);

    // Priority select of the address the stage fetches next
    always_comb begin
        next_pc  = pc;
        redirect = 1'b0;
        if (flush) begin
            next_pc  = new_pc;
            redirect = 1'b1;
        end else if (branch_flag) begin
            next_pc  = branch_target;
            redirect = 1'b1;
        end else if (advance) begin
            next_pc  = pc + PC_STEP;   // wraps modulo 2^32
        end else begin
            next_pc  = pc;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM over a
// req/ack handshake and presents (pc, inst) to the IF/ID register.
// Optional feature macro: INST_FETCH_ALIGN_CHECK_EN -- when defined, a
// misaligned PC raises a fetch exception and halts fetch until a flush;
// when undefined the ROM address is forced word aligned and if_excp stays 0.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_signal,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    input  logic              flush,
    input  logic [31:0]       new_pc,
    output logic              rom_req,
    output logic [31:0]       rom_addr,
    input  logic              rom_ack,
    input  logic [31:0]       rom_data,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_excp
);

    // Architectural state
    if_state_e         state_r;
    logic [31:0]       pc_r;
    logic [31:0]       req_addr_r;     // address of the outstanding request
    logic              hold_valid_r;   // response parked while the slot was busy
    logic [31:0]       hold_pc_r;
    logic [31:0]       hold_inst_r;
    logic              halt_r;         // fetch stopped after an alignment fault
    logic              valid_r;
    logic [31:0]       slot_pc_r;
    logic [INST_W-1:0] slot_inst_r;
    logic              excp_r;

    // Combinational decisions
    if_state_e         state_s;
    logic              consume_s;
    logic              slot_free_s;
    logic              redirect_s;
    logic              advance_s;
    logic [31:0]       next_pc_s;
    logic              rom_req_s;
    logic [31:0]       rom_addr_s;
    logic              req_start_s;
    logic              load_s;
    logic [31:0]       load_pc_s;
    logic [INST_W-1:0] load_inst_s;
    logic              load_excp_s;
    logic              hold_load_s;
    logic              hold_clear_s;
    logic              misalign_s;
    logic              unused_ctrl_s;

    // Bits [5:2] of the stall vector belong to later stages
    assign unused_ctrl_s = ^ctrl_signal[CTRL_W-1:2];

    assign consume_s   = valid_r & ~ctrl_signal[CTRL_IF_STALL];
    assign slot_free_s = ~valid_r | consume_s;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign misalign_s  = (pc_r[1:0] != 2'b00);
`else
    // Without the check a misaligned PC simply fetches its containing word
    assign misalign_s  = 1'b0;
`endif

    if_pc_next u_pc_next (
        .pc            (pc_r),
        .advance       (advance_s),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .next_pc       (next_pc_s),
        .redirect      (redirect_s)
    );

    // Fetch sequencer: next state, ROM request and slot-load decisions
    always_comb begin
        state_s      = state_r;
        rom_req_s    = 1'b0;
        rom_addr_s   = req_addr_r;
        req_start_s  = 1'b0;
        advance_s    = 1'b0;
        load_s       = 1'b0;
        load_pc_s    = pc_r;
        load_inst_s  = rom_data;
        load_excp_s  = 1'b0;
        hold_load_s  = 1'b0;
        hold_clear_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                rom_addr_s = pc_r;
                if (hold_valid_r) begin
                    // Drain the parked response before fetching anything new
                    if (slot_free_s && !redirect_s) begin
                        load_s       = 1'b1;
                        load_pc_s    = hold_pc_r;
                        load_inst_s  = hold_inst_r;
                        hold_clear_s = 1'b1;
                    end else begin
                        hold_clear_s = 1'b0;
                    end
                end else if (slot_free_s && !ctrl_signal[CTRL_HOLD_PC] &&
                             !redirect_s && !halt_r) begin
                    if (misalign_s) begin
                        // Present the faulting PC instead of issuing a read
                        load_s      = 1'b1;
                        load_pc_s   = pc_r;
                        load_inst_s = NOP_WORD;
                        load_excp_s = 1'b1;
                    end else begin
                        rom_req_s = 1'b1;
                        if (rom_ack) begin
                            load_s    = 1'b1;
                            load_pc_s = pc_r;
                            advance_s = 1'b1;
                        end else begin
                            req_start_s = 1'b1;
                            state_s     = ST_WAIT;
                        end
                    end
                end else begin
                    rom_req_s = 1'b0;
                end
            end
            ST_WAIT: begin
                rom_req_s = 1'b1;
                if (redirect_s) begin
                    // A response still owed to the old path must be swallowed
                    state_s = rom_ack ? ST_RUN : ST_DROP;
                end else if (rom_ack) begin
                    advance_s = 1'b1;
                    state_s   = ST_RUN;
                    if (slot_free_s) begin
                        load_s    = 1'b1;
                        load_pc_s = req_addr_r;
                    end else begin
                        hold_load_s = 1'b1;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                // Redirects here only move pc; the stale ack ends the drop
                rom_req_s = 1'b1;
                if (rom_ack) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // Program counter, sequencer state and outstanding request address
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            pc_r       <= RESET_PC;
            state_r    <= ST_RUN;
            req_addr_r <= 32'h0000_0000;
        end else begin
            pc_r    <= next_pc_s;
            state_r <= state_s;
            if (req_start_s) begin
                req_addr_r <= pc_r;
            end
        end
    end

    // One-word hold register for a response that arrives while the slot is busy
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            hold_valid_r <= 1'b0;
            hold_pc_r    <= 32'h0000_0000;
            hold_inst_r  <= NOP_WORD;
        end else if (redirect_s) begin
            hold_valid_r <= 1'b0;
        end else if (hold_load_s) begin
            hold_valid_r <= 1'b1;
            hold_pc_r    <= req_addr_r;
            hold_inst_r  <= rom_data;
        end else if (hold_clear_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Fetch halt after an alignment exception; only a flush restarts fetch
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            halt_r <= 1'b0;
        end else if (flush) begin
            halt_r <= 1'b0;
        end else if (load_excp_s) begin
            halt_r <= 1'b1;
        end
    end

    // Output slot towards IF/ID: cleared on redirect or consume, reloaded on fetch
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            valid_r     <= 1'b0;
            slot_pc_r   <= 32'h0000_0000;
            slot_inst_r <= NOP_WORD;
            excp_r      <= 1'b0;
        end else if (redirect_s) begin
            valid_r     <= 1'b0;
            slot_pc_r   <= 32'h0000_0000;
            slot_inst_r <= NOP_WORD;
            excp_r      <= 1'b0;
        end else if (load_s) begin
            valid_r     <= 1'b1;
            slot_pc_r   <= load_pc_s;
            slot_inst_r <= load_inst_s;
            excp_r      <= load_excp_s;
        end else if (consume_s) begin
            valid_r     <= 1'b0;
            slot_pc_r   <= 32'h0000_0000;
            slot_inst_r <= NOP_WORD;
            excp_r      <= 1'b0;
        end
    end

    // The request is decided in-cycle so a zero-wait ROM can ack immediately
    assign rom_req  = rom_req_s & (rst != RST_ACTIVE);
`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign rom_addr = rom_req ? rom_addr_s : 32'h0000_0000;
`else
    assign rom_addr = rom_req ? (rom_addr_s & WORD_MASK) : 32'h0000_0000;
`endif

    assign if_valid = valid_r;
    assign if_pc    = slot_pc_r;
    assign if_inst  = slot_inst_r;
    // Constant 0 unless the alignment check is built in
    assign if_excp  = excp_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed phases plus a randomized
// phase, checked against an in-order instruction-stream scoreboard.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ctrl_signal;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_excp;

    int n_cmp = 0;
    int n_err = 0;

    // ROM model: acks once a request has been held for lat cycles
    int          lat = 0;
    int          lat_next = 0;
    int          wait_cnt = 0;
    logic [31:0] key = 32'h0000_0000;

    // Scoreboard state
    logic [31:0] exp_pc;
    bit          sb_en = 1'b1;
    bit          gap_en = 1'b0;
    bit          chk_noreq = 1'b0;
    int          cyc = 0;
    int          last_cons = -1;
    int          n_cons = 0;
    logic        prev_req, prev_ack, prev_frz;
    logic [31:0] prev_addr, prev_pc, prev_inst;

    inst_fetch dut (
        .clk(clk), .rst(rst), .ctrl_signal(ctrl_signal),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .new_pc(new_pc),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_excp(if_excp)
    );

    always #5 clk = ~clk;

    assign rom_ack  = rom_req && (wait_cnt >= lat);
    assign rom_data = rom_ack ? (rom_addr ^ key) : 32'hDEAD_BEEF;

    // Cycles the current request has been waiting
    always @(posedge clk) begin
        if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    // Word the ROM holds for an instruction at address a
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic note_prev();
        prev_req  = rom_req;
        prev_ack  = rom_ack;
        prev_addr = rom_addr;
        prev_pc   = if_pc;
        prev_inst = if_inst;
    endtask

    // One clock cycle: drive inputs at negedge, check at negedge+1
    task automatic step(input logic [5:0] c, input logic br, input logic [31:0] bt,
                        input logic fl, input logic [31:0] np);
        @(negedge clk);
        lat = lat_next;
        ctrl_signal = c; branch_flag = br; branch_target = bt; flush = fl; new_pc = np;
        #1;
        cyc++;
        if (sb_en) begin
            if (prev_req && !prev_ack) begin
                chk("req_held", {31'b0, rom_req}, 32'd1);
                chk("addr_stable", rom_addr, prev_addr);
            end
            if (!if_valid) begin
                chk("empty_pc", if_pc, 32'h0);
                chk("empty_inst", if_inst, 32'h0);
            end
            if (prev_frz) begin
                chk("frozen_pc", if_pc, prev_pc);
                chk("frozen_inst", if_inst, prev_inst);
            end
            if (chk_noreq && if_valid && c[1]) chk("no_req_stalled", {31'b0, rom_req}, 32'd0);
            if (if_valid && !c[1]) begin
                chk("stream_pc", if_pc, exp_pc);
                chk("stream_inst", if_inst, rom_word(exp_pc));
                if (gap_en && last_cons >= 0) chk("gap", 32'(cyc - last_cons), 32'(lat + 1));
                last_cons = cyc;
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
        end
        if (fl) exp_pc = np;
        else if (br) exp_pc = bt;
        prev_frz = if_valid && c[1] && !fl && !br;
        note_prev();
    endtask

    task automatic idle();
        step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Assert reset, check the reset state, release and check the first request
    task automatic do_reset(input logic [31:0] k);
        @(negedge clk);
        rst = 1'b0; ctrl_signal = 6'b0; branch_flag = 1'b0; flush = 1'b0;
        branch_target = 32'h0; new_pc = 32'h0; lat = 0; lat_next = 0;
        #1;
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_excp", {31'b0, if_excp}, 32'd0);
        chk("rst_req", {31'b0, rom_req}, 32'd0);
        chk("rst_addr", rom_addr, 32'h0);
        key = k;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("first_req", {31'b0, rom_req}, 32'd1);
        chk("first_addr", rom_addr, 32'h0);
        exp_pc = 32'h0; prev_frz = 1'b0; last_cons = -1;
        note_prev();
    endtask

    initial begin
        rst = 1'b0; ctrl_signal = 6'b0; branch_flag = 1'b0; flush = 1'b0;
        branch_target = 32'h0; new_pc = 32'h0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_frz = 1'b0;
        prev_addr = 32'h0; prev_pc = 32'h0; prev_inst = 32'h0; exp_pc = 32'h0;

        // Zero-wait ROM returning its address: one instruction per cycle
        do_reset(32'h0000_0000);
        gap_en = 1'b1;
        repeat (12) idle();
        chk("zw_pc_after_12", if_pc, 32'd44);

        // Full stall for four cycles: frozen slot, no requests, then resume
        gap_en = 1'b0; chk_noreq = 1'b1;
        repeat (4) step(6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_noreq = 1'b0;
        repeat (6) idle();

        // ROM acking three cycles late: one instruction every four cycles
        lat_next = 3; last_cons = -1; gap_en = 1'b1;
        repeat (24) idle();
        gap_en = 1'b0;

        // Branch during a wait: the stale response must never reach the slot
        for (int i = 0; i < 20; i++) begin
            idle();
            if (rom_req && !rom_ack && wait_cnt == 1) break;
        end
        chk("wait_reached", {31'b0, (rom_req && !rom_ack)}, 32'd1);
        step(6'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            idle();
            if (if_valid) break;
        end
        chk("branch_valid", {31'b0, if_valid}, 32'd1);
        chk("branch_pc", if_pc, 32'h0000_0100);

        // Flush beats a simultaneous branch
        lat_next = 0;
        step(6'b0, 1'b1, 32'h0000_0240, 1'b1, 32'h0000_0180);
        for (int i = 0; i < 20; i++) begin
            idle();
            if (if_valid) break;
        end
        chk("flush_pc", if_pc, 32'h0000_0180);
        repeat (3) idle();

        // PC wraps past the top of the address space
        step(6'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        repeat (5) idle();

        // Randomized traffic with a scrambled ROM image
        do_reset(32'h5A5A_C3C3);
        n_cons = 0;
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  c;
            logic        br, fl;
            c = 6'($urandom);
            c[1] = ($urandom_range(0, 3) == 0);
            c[0] = ($urandom_range(0, 4) == 0);
            br = ($urandom_range(0, 11) == 0);
            fl = ($urandom_range(0, 24) == 0);
            lat_next = $urandom_range(0, 3);
            step(c, br, $urandom & 32'h0000_FFFC, fl, $urandom & 32'h0000_FFFC);
        end
        chk("rand_progress", {31'b0, (n_cons >= 40)}, 32'd1);

        // Misaligned target
        lat_next = 0;
        repeat (3) idle();
`ifdef INST_FETCH_ALIGN_CHECK_EN
        sb_en = 1'b0;
        step(6'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
        step(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("mis_no_req", {31'b0, rom_req}, 32'd0);
        step(6'b000010, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("mis_excp", {31'b0, if_excp}, 32'd1);
        chk("mis_valid", {31'b0, if_valid}, 32'd1);
        chk("mis_pc", if_pc, 32'h0000_0102);
        chk("mis_inst", if_inst, 32'h0);
        repeat (3) begin
            idle();
            chk("mis_halt_req", {31'b0, rom_req}, 32'd0);
        end
        step(6'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
        idle();
        chk("mis_restart_req", {31'b0, rom_req}, 32'd1);
        chk("mis_restart_addr", rom_addr, 32'h0000_0200);
`else
        step(6'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
        idle();
        chk("mis_req", {31'b0, rom_req}, 32'd1);
        chk("mis_addr_aligned", rom_addr, 32'h0000_0100);
        idle();
        chk("mis_pc", if_pc, 32'h0000_0102);
        chk("mis_inst", if_inst, 32'h0000_0100 ^ key);
        chk("mis_excp", {31'b0, if_excp}, 32'd0);
        repeat (3) idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
